// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC flit definitions for the node-side packetizer and depacketizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int NODE_ID_W = 2;
    localparam int LEN_W     = 4;
    localparam int HDR_W     = 54;

    localparam logic [1:0] FLIT_HEAD = 2'b01;

    typedef struct packed {
        logic [1:0]           ftype;
        logic [NODE_ID_W-1:0] src;
        logic [NODE_ID_W-1:0] dst;
        logic [LEN_W-1:0]     len;
        logic [HDR_W-1:0]     hdr;
    } head_flit_t;

    function automatic head_flit_t decode_head(input logic [63:0] flit);
        return head_flit_t'(flit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_rx_depacketizer_if.sv
// ============================================================================
// Module      : noc_rx_depacketizer_if
// Description : Flit-in / message-out bundle of the NoC receive endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_rx_depacketizer_if #(
    parameter int FLIT_W      = 64,
    parameter int MAX_PAYLOAD = 8
);
    logic [FLIT_W-1:0]             flit_data_i;
    logic                          flit_valid_i;
    logic                          flit_ready_o;
    logic                          msg_valid_o;
    logic                          msg_ready_i;
    logic [1:0]                    msg_src_o;
    logic [3:0]                    msg_len_o;
    logic [53:0]                   msg_hdr_o;
    logic [MAX_PAYLOAD*FLIT_W-1:0] msg_payload_o;
    logic                          err_o;
    logic [15:0]                   pkt_cnt_o;
    logic [15:0]                   err_cnt_o;

    // Endpoint view
    modport slave (
        input  flit_data_i, flit_valid_i, msg_ready_i,
        output flit_ready_o, msg_valid_o, msg_src_o, msg_len_o, msg_hdr_o,
               msg_payload_o, err_o, pkt_cnt_o, err_cnt_o
    );

    // Router + consumer view
    modport master (
        output flit_data_i, flit_valid_i, msg_ready_i,
        input  flit_ready_o, msg_valid_o, msg_src_o, msg_len_o, msg_hdr_o,
               msg_payload_o, err_o, pkt_cnt_o, err_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/noc_rx_payload_buf.sv
// ============================================================================
// Module      : noc_rx_payload_buf
// Description : MAX_PAYLOAD x FLIT_W payload store; a reset per-slot valid bit
//               masks slots never written since reset so the read-out starts at 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_rx_payload_buf #(
    parameter int FLIT_W      = 64,
    parameter int MAX_PAYLOAD = 8,
    parameter int IDX_W       = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          wr_en,
    input  wire logic [IDX_W-1:0]              wr_idx,
    input  wire logic [FLIT_W-1:0]             wr_data,
    output logic      [MAX_PAYLOAD*FLIT_W-1:0] rd_data
);

    for (genvar k = 0; k < MAX_PAYLOAD; k++) begin : g_slot
        logic [FLIT_W-1:0] mem;
        logic              slot_vld;
        logic              hit;

        assign hit = wr_en && (wr_idx == IDX_W'(k));

        always_ff @(posedge clk) begin
            if (hit) begin
                mem <= wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_vld <= 1'b0;
            end else if (hit) begin
                slot_vld <= 1'b1;
            end
        end

        assign rd_data[k*FLIT_W +: FLIT_W] = slot_vld ? mem : '0;
    end

endmodule

`default_nettype wire

// File: rtl/noc_rx_depacketizer.sv
// ============================================================================
// Module      : noc_rx_depacketizer
// Description : Mesh22 node receive endpoint: validates head flits, gathers the
//               payload and presents one whole message at a time.
//               Define NOC_RX_STATS_EN to enable saturating message/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_rx_depacketizer
    import noc_pkg::*;
#(
    parameter int NODE_ID     = 0,
    parameter int FLIT_W      = 64,
    parameter int MAX_PAYLOAD = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    noc_rx_depacketizer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DROP    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam logic [NODE_ID_W-1:0] MY_ID   = NODE_ID_W'(NODE_ID);
    localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(MAX_PAYLOAD);

    state_t               state, state_nxt;
    logic [LEN_W-1:0]     cnt, cnt_nxt;
    logic [LEN_W-1:0]     len_q;
    logic [NODE_ID_W-1:0] src_q;
    logic [HDR_W-1:0]     hdr_q;
    logic                 err_q, err_nxt;
    logic                 hdr_load;
    logic                 wr_en;
    logic                 xfer;
    head_flit_t           head;

    assign head             = decode_head(bus.flit_data_i[63:0]);
    assign bus.flit_ready_o = (state != DELIVER);
    assign bus.msg_valid_o  = (state == DELIVER);
    assign xfer             = bus.flit_valid_i && bus.flit_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
            src_q <= '0;
            hdr_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
            if (hdr_load) begin
                len_q <= head.len;
                src_q <= head.src;
                hdr_q <= head.hdr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        hdr_load  = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (head.ftype != FLIT_HEAD) begin
                        err_nxt = 1'b1;
                    end else if (head.dst != MY_ID || head.len > MAX_LEN) begin
                        // A zero-length stray head has nothing to swallow.
                        err_nxt   = 1'b1;
                        cnt_nxt   = head.len;
                        state_nxt = (head.len == '0) ? IDLE : DROP;
                    end else begin
                        hdr_load  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = (head.len == '0) ? DELIVER : RECV;
                    end
                end
            end
            RECV: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) begin
                        state_nxt = DELIVER;
                    end
                end
            end
            DROP: begin
                if (xfer) begin
                    cnt_nxt = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DELIVER: begin
                if (bus.msg_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    noc_rx_payload_buf #(
        .FLIT_W      (FLIT_W),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .IDX_W       (LEN_W)
    ) u_payload_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (cnt),
        .wr_data (bus.flit_data_i),
        .rd_data (bus.msg_payload_o)
    );

    assign bus.msg_src_o = src_q;
    assign bus.msg_len_o = len_q;
    assign bus.msg_hdr_o = hdr_q;
    assign bus.err_o     = err_q;

`ifdef NOC_RX_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (state == DELIVER && bus.msg_ready_i && pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (err_q && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign bus.pkt_cnt_o = pkt_cnt;
    assign bus.err_cnt_o = err_cnt;
`else
    assign bus.pkt_cnt_o = '0;
    assign bus.err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/noc_rx_depacketizer.md
Name: noc_rx_depacketizer

Overview:
- Node-side receive endpoint of the 2x2 mesh NoC.
- Accepts the 64-bit valid/ready flit stream that a Mesh22 router ejects toward its local node.
- Validates the head flit, collects the payload flits it announces, and presents one whole message at a time to the core side.
- Counterpart of the node-side packetizer that injects flits into the router; one instance per node.

Parameters:
NODE_ID, 0, this node's mesh address (0..3); heads addressed elsewhere are dropped
FLIT_W, 64, flit width in bits
MAX_PAYLOAD, 8, max payload flits per message (1..15)

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
flit_data_i  in  FLIT_W  flit from router
flit_valid_i  in  1  flit valid
flit_ready_o  out  1  block can accept a flit
msg_valid_o  out  1  assembled message available
msg_ready_i  in  1  consumer accepts message
msg_src_o  out  2  source node of message
msg_len_o  out  4  number of valid payload flits
msg_hdr_o  out  54  head-flit user field
msg_payload_o  out  MAX_PAYLOAD*FLIT_W  payload; flit k at bits [k*64 +: 64]
err_o  out  1  one-cycle pulse on a protocol error
pkt_cnt_o  out  16  delivered-message count (optional feature)
err_cnt_o  out  16  error count (optional feature)

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high. All state resets on rst assertion, without waiting for a clock edge.
- Reset values: state IDLE; flit_ready_o=1; msg_valid_o=0; msg_src_o, msg_len_o, msg_hdr_o, msg_payload_o=0; err_o=0; counters=0.
- A flit transfers when flit_valid_i && flit_ready_o at a rising clk edge.
- Head flit format:
  - [63:62] type, must be 2'b01
  - [61:60] src
  - [59:58] dst
  - [57:54] len
  - [53:0] hdr
- Payload flits are raw 64-bit words, counted by len; they carry no type bits.
- FSM states and transitions:
  - IDLE, ready=1. On a transfer:
    - type!=01 -> discard the flit, err_o pulse, stay IDLE.
    - dst!=NODE_ID or len>MAX_PAYLOAD -> latch len into cnt, err_o pulse, go to DROP.
    - len==0 -> latch src/hdr/len, go to DELIVER on the next cycle.
    - otherwise -> latch src/hdr/len, cnt=0, go to RECV.
  - RECV, ready=1. Each transfer writes payload[cnt] and increments cnt; when cnt==len-1 on a transfer, go to DELIVER. Bubbles (valid=0) hold state.
  - DROP, ready=1. Consumes len flits without storing them, then returns to IDLE.
  - DELIVER, ready=0, msg_valid_o=1.
    - Outputs are stable until msg_ready_i.
    - On msg_valid_o && msg_ready_i -> go to IDLE; flit_ready_o rises in the same cycle as state IDLE.
- Latency: msg_valid_o asserts the cycle after the last payload flit transfers (or after a len==0 head).
- Payload slots >= msg_len_o retain stale data; consumers use only the first msg_len_o flits.
- msg_ready_i is ignored outside DELIVER. msg_valid_o must never drop without a handshake.
- cnt is 4 bits wide and never wraps: len is capped at MAX_PAYLOAD before entering RECV.
- Reset mid-message: the partial message is discarded. The router side is expected to be reset by the same rst.
- Error and accept cases share the same cycle: err_o pulses in the cycle after the offending head transfers.

Optional Feature:
NOC_RX_STATS_EN
- Defined: pkt_cnt_o increments on each DELIVER handshake; err_cnt_o increments on each err_o pulse. Both are 16-bit and saturate at 16'hFFFF.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- noc_pkg holds:
  - the flit type localparams (HEAD=2'b01)
  - the head-flit packed struct (type, src, dst, len, hdr)
  - NODE_ID_W=2, LEN_W=4, HDR_W=54
- This same package is shared with the future packetizer.
- One sub-module: noc_rx_payload_buf.
  - MAX_PAYLOAD x FLIT_W register array.
  - Write-enable plus index input; flat read-out bus.
  - No reset on data.

Test Plan:
- NODE_ID=2; head {01,src=1,dst=2,len=3,hdr=54'h1234}, then payload flits A,B,C back-to-back -> msg_valid_o one cycle after C; src=1, len=3, hdr=1234h, payload[0..2]=A,B,C; flit_ready_o=0 until handshake.
- Same message with 2-cycle bubbles between flits and msg_ready_i held low for 5 cycles -> outputs stable all 5 cycles; flit_ready_o=0 throughout; ready returns the cycle after the handshake.
- Head with dst=3 and len=2, then 2 payloads, then a valid len=1 message to this node -> err_o one pulse, no message for the first; the second is delivered correctly.
- Head with type=2'b00 -> err_o pulse, state stays IDLE; head with len=0 -> msg_valid_o next cycle with msg_len_o=0.
- Head with len=9 (MAX_PAYLOAD=8) -> 9 flits dropped, err_o pulse, no msg_valid_o.
- With NOC_RX_STATS_EN: deliver 3 messages and inject 2 errors -> pkt_cnt_o=3, err_cnt_o=2; assert rst mid-RECV -> all outputs return to reset values immediately, no message delivered.
